// File: rtl/tracker_pkg.sv
// Shared encodings for the streaming extreme tracker: FSM states and the tracking-mode values.
package tracker_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;
endpackage

// File: rtl/comp.sv
// Combinational unsigned magnitude comparator, zero latency, no flow control.
module comp #(
  parameter int n = 8
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         agb,
  output logic         alb
);
  assign agb = (a > b);
  assign alb = (a < b);
endmodule

// File: rtl/mode_extreme_tracker.sv
// Per-frame running max/min of a valid/ready sample stream; result 1 cycle after the last sample, input stalled while a result is held.
// Optional TRACKER_INDEX_EN adds out_index, the zero-based position of the winning sample.
module mode_extreme_tracker
  import tracker_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m,
  input  logic [N-1:0]  in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [N-1:0]  out_data,
  output logic [CW-1:0] out_count,
  output logic          out_valid,
  input  logic          out_ready
`ifdef TRACKER_INDEX_EN
  ,
  output logic [CW-1:0] out_index
`endif
);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef TRACKER_INDEX_EN
  logic [CW-1:0] idx_q, idx_d;
`endif

  logic accept;
  logic agb, alb;
  logic upd;

  comp #(.n(N)) u_comp (
    .a   (in_data),
    .b   (acc_q),
    .agb (agb),
    .alb (alb)
  );

  // Strict compare: equal samples never displace the current extreme.
  assign upd    = (mode_q == MODE_MAX) ? agb : alb;
  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
`ifdef TRACKER_INDEX_EN
    idx_d   = idx_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d   = in_data;
          mode_d  = m;
          cnt_d   = CW'(1);
`ifdef TRACKER_INDEX_EN
          idx_d   = '0;
`endif
          state_d = in_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          if (upd) begin
            acc_d = in_data;
`ifdef TRACKER_INDEX_EN
            // cnt_q is this sample's position; it freezes once the counter saturates.
            idx_d = cnt_q;
`endif
          end
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
          if (in_last) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      mode_q  <= MODE_MIN;
      cnt_q   <= '0;
`ifdef TRACKER_INDEX_EN
      idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
`ifdef TRACKER_INDEX_EN
      idx_q   <= idx_d;
`endif
    end
  end

  assign out_valid = (state_q == ST_HOLD);
  assign in_ready  = ~out_valid;
  assign out_data  = acc_q;
  assign out_count = cnt_q;
`ifdef TRACKER_INDEX_EN
  assign out_index = idx_q;
`endif
endmodule
